// File: rtl/cmd_dispatch_pkg.sv
// Shared opcodes, response codes, FIFO entry layout and FSM states for the
// command dispatcher.
package cmd_dispatch_pkg;

    localparam logic [7:0] OP_NOP     = 8'h00;
    localparam logic [7:0] OP_SPI_WR  = 8'h01;
    localparam logic [7:0] OP_SPI_RD  = 8'h02;
    localparam logic [7:0] OP_IMG_CAP = 8'h10;
    localparam logic [7:0] OP_IMG_RD  = 8'h11;

    localparam logic [7:0] RSP_OK      = 8'h00;
    localparam logic [7:0] RSP_ERR_OPC = 8'h01;
    localparam logic [7:0] RSP_TIMEOUT = 8'h02;

    typedef struct packed {
        logic [7:0] cmd;
        logic [7:0] addr_msb;
        logic [7:0] addr_lsb;
        logic [7:0] data_msb;
        logic [7:0] data_lsb;
    } cmd_entry_t;

    localparam int ENTRY_W = $bits(cmd_entry_t);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE_SPI = 3'd1,
        ST_WAIT_SPI  = 3'd2,
        ST_ISSUE_IMG = 3'd3,
        ST_WAIT_IMG  = 3'd4,
        ST_RESP      = 3'd5
    } state_t;

endpackage

// File: rtl/cmd_dispatcher_if.sv
// Command, back-end resource and response signals of the dispatcher, with
// the dispatcher side as master and the surrounding system as slave.
interface cmd_dispatcher_if;
    import cmd_dispatch_pkg::*;

    // Handshakes: a response transfers on the rising edge where rspValid and
    // rspReady are both high, with rspCode/rspData stable until then; a
    // resource request (xReq level) is accepted on the edge where xAck is high,
    // and xDone marks completion of that single outstanding transaction.
    logic        cmdUpdate;
    logic [7:0]  cmd;
    logic [7:0]  addrLsb;
    logic [7:0]  addrMsb;
    logic [7:0]  dataLsb;
    logic [7:0]  dataMsb;

    logic        spiReq;
    logic        spiWr;
    logic [15:0] spiAddr;
    logic [15:0] spiWdata;
    logic        spiAck;
    logic        spiDone;
    logic [15:0] spiRdata;

    logic        imgReq;
    logic        imgOp;
    logic        imgAck;
    logic        imgDone;

    logic        rspValid;
    logic [7:0]  rspCode;
    logic [15:0] rspData;
    logic        rspReady;

    logic        fifoFull;
    logic [7:0]  dropCnt;
    logic        busy;
    state_t      fsm_state;

    modport master (
        input  cmdUpdate, cmd, addrLsb, addrMsb, dataLsb, dataMsb,
        output spiReq, spiWr, spiAddr, spiWdata,
        input  spiAck, spiDone, spiRdata,
        output imgReq, imgOp,
        input  imgAck, imgDone,
        output rspValid, rspCode, rspData,
        input  rspReady,
        output fifoFull, dropCnt, busy, fsm_state
    );

    modport slave (
        output cmdUpdate, cmd, addrLsb, addrMsb, dataLsb, dataMsb,
        input  spiReq, spiWr, spiAddr, spiWdata,
        output spiAck, spiDone, spiRdata,
        input  imgReq, imgOp,
        output imgAck, imgDone,
        input  rspValid, rspCode, rspData,
        output rspReady,
        input  fifoFull, dropCnt, busy, fsm_state
    );

endinterface

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; a push while full is rejected and flagged on drop,
// with fullness judged before any same-cycle pop.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign drop    = push && full;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cmd_dispatcher.sv
// Buffers decoded host commands and runs them one at a time on the SPI master
// or the image buffer, returning one status response per command.
module cmd_dispatcher
    import cmd_dispatch_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input logic          clk40M,
    input logic          rst,
    cmd_dispatcher_if.master bus
);

    localparam logic [31:0] TO_LAST = (TIMEOUT_CYC == 0) ? 32'd0 : 32'(TIMEOUT_CYC - 1);

    state_t      state;
    state_t      state_n;
    cmd_entry_t  cur;
    cmd_entry_t  cur_n;
    cmd_entry_t  in_entry;
    cmd_entry_t  head;
    logic [7:0]  rsp_code;
    logic [7:0]  rsp_code_n;
    logic [15:0] rsp_data;
    logic [15:0] rsp_data_n;
    logic [31:0] to_cnt;
    logic [7:0]  drop_cnt;
    logic        to_hit;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_drop;

    assign in_entry = {bus.cmd, bus.addrMsb, bus.addrLsb, bus.dataMsb, bus.dataLsb};

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk40M),
        .rst   (rst),
        .push  (bus.cmdUpdate),
        .pop   (pop),
        .wdata (in_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .drop  (fifo_drop)
    );

    // Cycle n of a transaction (n = 0 on the first ISSUE cycle) times out when
    // n reaches TIMEOUT_CYC-1, so RESP starts TIMEOUT_CYC cycles after req rose.
    assign to_hit = (TIMEOUT_CYC != 0) && (to_cnt == TO_LAST);

    always_comb begin
        state_n    = state;
        cur_n      = cur;
        rsp_code_n = rsp_code;
        rsp_data_n = rsp_data;
        pop        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    cur_n      = head;
                    rsp_code_n = RSP_OK;
                    rsp_data_n = 16'h0000;
                    case (head.cmd)
                        OP_SPI_WR, OP_SPI_RD:  state_n = ST_ISSUE_SPI;
                        OP_IMG_CAP, OP_IMG_RD: state_n = ST_ISSUE_IMG;
                        OP_NOP:                state_n = ST_RESP;
                        default: begin
                            state_n    = ST_RESP;
                            rsp_code_n = RSP_ERR_OPC;
                        end
                    endcase
                end
            end
            ST_ISSUE_SPI, ST_WAIT_SPI: begin
                if (bus.spiDone && (state == ST_WAIT_SPI || bus.spiAck)) begin
                    state_n    = ST_RESP;
                    rsp_code_n = RSP_OK;
                    rsp_data_n = (cur.cmd == OP_SPI_RD) ? bus.spiRdata : 16'h0000;
                end else if (to_hit) begin
                    state_n    = ST_RESP;
                    rsp_code_n = RSP_TIMEOUT;
                    rsp_data_n = 16'h0000;
                end else if (state == ST_ISSUE_SPI && bus.spiAck) begin
                    state_n = ST_WAIT_SPI;
                end
            end
            ST_ISSUE_IMG, ST_WAIT_IMG: begin
                if (bus.imgDone && (state == ST_WAIT_IMG || bus.imgAck)) begin
                    state_n    = ST_RESP;
                    rsp_code_n = RSP_OK;
                    rsp_data_n = 16'h0000;
                end else if (to_hit) begin
                    state_n    = ST_RESP;
                    rsp_code_n = RSP_TIMEOUT;
                    rsp_data_n = 16'h0000;
                end else if (state == ST_ISSUE_IMG && bus.imgAck) begin
                    state_n = ST_WAIT_IMG;
                end
            end
            ST_RESP: begin
                if (bus.rspReady) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk40M) begin
        if (rst) begin
            state    <= ST_IDLE;
            cur      <= '0;
            rsp_code <= 8'h00;
            rsp_data <= 16'h0000;
            to_cnt   <= 32'd0;
            drop_cnt <= 8'h00;
        end else begin
            state    <= state_n;
            cur      <= cur_n;
            rsp_code <= rsp_code_n;
            rsp_data <= rsp_data_n;
            if (state == ST_IDLE || state == ST_RESP) begin
                to_cnt <= 32'd0;
            end else begin
                to_cnt <= to_cnt + 32'd1;
            end
            if (fifo_drop && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    assign bus.spiReq    = (state == ST_ISSUE_SPI);
    assign bus.spiWr     = (cur.cmd == OP_SPI_WR);
    assign bus.spiAddr   = {cur.addr_msb, cur.addr_lsb};
    assign bus.spiWdata  = {cur.data_msb, cur.data_lsb};
    assign bus.imgReq    = (state == ST_ISSUE_IMG);
    assign bus.imgOp     = (cur.cmd == OP_IMG_RD);
    assign bus.rspValid  = (state == ST_RESP);
    assign bus.rspCode   = rsp_code;
    assign bus.rspData   = rsp_data;
    assign bus.fifoFull  = fifo_full;
    assign bus.dropCnt   = drop_cnt;
    assign bus.busy      = (state != ST_IDLE) || !fifo_empty;
    assign bus.fsm_state = state;

endmodule
